// File: rtl/hls_mem_preloader.sv
// hls_mem_preloader
//   Upstream stage of the HLS-generated `main`. It collects a byte stream
//   into little-endian words, writes them through the slave memory port, then
//   pulses start_port and times the run until done_port or a timeout.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   go, base_addr         : open a load session at base_addr (IDLE only)
//   byte_valid/data/ready : preload byte handshake
//   load_done             : end of preload (COLLECT only)
//   S_we_ram, S_oe_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size : slave write port
//   start_port, done_port : run control towards `main`
//   busy, run_done, timed_out, overflow, cycle_count : status and result
module hls_mem_preloader #(
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 64,
   parameter int SIZE_W         = 7,
   parameter int MEM_SIZE       = 256,
   parameter int TIMEOUT_CYCLES = 200000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              load_done,
   output logic              S_we_ram,
   output logic              S_oe_ram,
   output logic [ADDR_W-1:0] S_addr_ram,
   output logic [DATA_W-1:0] S_Wdata_ram,
   output logic [SIZE_W-1:0] S_data_ram_size,
   output logic              start_port,
   input  logic              done_port,
   output logic              busy,
   output logic              run_done,
   output logic              timed_out,
   output logic              overflow,
   output logic [31:0]       cycle_count
);

   localparam int BYTES  = DATA_W / 8;
   localparam int BCNT_W = $clog2(BYTES + 1);
   localparam int TOT_W  = $clog2(MEM_SIZE + 1);
   localparam logic [BCNT_W-1:0] BYTES_C   = BCNT_W'(BYTES);
   localparam logic [TOT_W-1:0]  MEM_C     = TOT_W'(MEM_SIZE);
   localparam logic [31:0]       TIMEOUT_C = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_WRITE, S_WGAP, S_START, S_RUN, S_REPORT
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   ptr_reg, ptr_next;
   logic [DATA_W-1:0]   word_reg, word_next;
   logic [BCNT_W-1:0]   bcnt_reg, bcnt_next;
   logic [TOT_W-1:0]    total_reg, total_next;
   logic                flush_reg, flush_next;
   logic                ovf_reg, ovf_next;
   logic                to_reg, to_next;
   logic [31:0]         ccount_reg, ccount_next;
   logic [31:0]         cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   waddr_reg, waddr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [SIZE_W-1:0]   wsize_reg, wsize_next;

   logic accept;
   logic keep;

   assign accept = (state_reg == S_COLLECT) && byte_valid;
   // Bytes past the preload memory size are still handshaked but dropped.
   assign keep   = accept && (total_reg < MEM_C);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         ptr_reg    <= '0;
         word_reg   <= '0;
         bcnt_reg   <= '0;
         total_reg  <= '0;
         flush_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
         to_reg     <= 1'b0;
         ccount_reg <= '0;
         cnt_reg    <= '0;
         waddr_reg  <= '0;
         wdata_reg  <= '0;
         wsize_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         word_reg   <= word_next;
         bcnt_reg   <= bcnt_next;
         total_reg  <= total_next;
         flush_reg  <= flush_next;
         ovf_reg    <= ovf_next;
         to_reg     <= to_next;
         ccount_reg <= ccount_next;
         cnt_reg    <= cnt_next;
         waddr_reg  <= waddr_next;
         wdata_reg  <= wdata_next;
         wsize_reg  <= wsize_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      word_next   = word_reg;
      bcnt_next   = bcnt_reg;
      total_next  = total_reg;
      flush_next  = flush_reg;
      ovf_next    = ovf_reg;
      to_next     = to_reg;
      ccount_next = ccount_reg;
      cnt_next    = cnt_reg;
      waddr_next  = waddr_reg;
      wdata_next  = wdata_reg;
      wsize_next  = wsize_reg;

      case (state_reg)
         S_IDLE: begin
            if (go) begin
               ptr_next    = base_addr;
               word_next   = '0;
               bcnt_next   = '0;
               total_next  = '0;
               flush_next  = 1'b0;
               ovf_next    = 1'b0;
               to_next     = 1'b0;
               ccount_next = '0;
               state_next  = S_COLLECT;
            end
         end

         S_COLLECT: begin
            if (keep) begin
               for (int k = 0; k < BYTES; k++) begin
                  if (bcnt_reg == BCNT_W'(k)) begin
                     word_next[8*k +: 8] = byte_data;
                  end
               end
               bcnt_next  = bcnt_reg + BCNT_W'(1);
               total_next = total_reg + TOT_W'(1);
            end
            if (accept && !keep) begin
               ovf_next = 1'b1;
            end
            if (load_done) begin
               flush_next = 1'b1;
            end

            // A byte arriving with load_done is packed before the flush decision.
            if (bcnt_next == BYTES_C) begin
               state_next = S_WRITE;
            end else if (load_done) begin
               state_next = (bcnt_next != '0) ? S_WRITE : S_START;
            end

            // Capture the write beat now so the port holds it after the write.
            if (state_next == S_WRITE) begin
               waddr_next = ptr_reg;
               wdata_next = word_next;
               wsize_next = SIZE_W'({bcnt_next, 3'b000});
            end
         end

         S_WRITE: begin
            ptr_next   = ptr_reg + ADDR_W'(bcnt_reg);
            bcnt_next  = '0;
            // Clearing the word keeps unused upper lanes zero on partial writes.
            word_next  = '0;
            state_next = S_WGAP;
         end

         S_WGAP: begin
            state_next = flush_reg ? S_START : S_COLLECT;
         end

         S_START, S_RUN: begin
            cnt_next = cnt_reg + 32'd1;
            if (done_port) begin
               ccount_next = cnt_reg;
               state_next  = S_REPORT;
            end else if (state_reg == S_START) begin
               state_next = S_RUN;
            end else if (cnt_reg >= TIMEOUT_C) begin
               to_next     = 1'b1;
               ccount_next = TIMEOUT_C;
               state_next  = S_REPORT;
            end
         end

         S_REPORT: begin
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // The START cycle itself is cycle 1 of the run.
      if (state_next == S_START) begin
         cnt_next = 32'd1;
      end
   end

   assign byte_ready      = (state_reg == S_COLLECT);
   assign S_we_ram        = (state_reg == S_WRITE);
   assign S_oe_ram        = 1'b0;
   assign S_addr_ram      = waddr_reg;
   assign S_Wdata_ram     = wdata_reg;
   assign S_data_ram_size = wsize_reg;
   assign start_port      = (state_reg == S_START);
   assign busy            = (state_reg != S_IDLE);
   assign run_done        = (state_reg == S_REPORT);
   assign timed_out       = to_reg;
   assign overflow        = ovf_reg;
   assign cycle_count     = ccount_reg;

endmodule

// File: tb/tb_hls_mem_preloader.sv
// tb_hls_mem_preloader
//   Directed and randomized load sessions against hls_mem_preloader built with
//   a 16-byte preload memory and a 50-cycle timeout. Expected writes and run
//   results are derived from the byte list and the chosen done_port delay.
module tb_hls_mem_preloader;

   localparam int MEM = 16;
   localparam int TO  = 50;

   logic        clock = 1'b0;
   logic        reset;
   logic        go;
   logic [9:0]  base_addr;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        load_done;
   logic        S_we_ram;
   logic        S_oe_ram;
   logic [9:0]  S_addr_ram;
   logic [63:0] S_Wdata_ram;
   logic [6:0]  S_data_ram_size;
   logic        start_port;
   logic        done_port;
   logic        busy;
   logic        run_done;
   logic        timed_out;
   logic        overflow;
   logic [31:0] cycle_count;

   int tests = 0;
   int fails = 0;
   int tick  = 0;
   int start_cnt = 0;
   logic [9:0]  wa_q[$];
   logic [63:0] wd_q[$];
   logic [6:0]  ws_q[$];

   hls_mem_preloader #(
      .ADDR_W(10), .DATA_W(64), .SIZE_W(7), .MEM_SIZE(MEM), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock), .reset(reset), .go(go), .base_addr(base_addr),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .load_done(load_done), .S_we_ram(S_we_ram), .S_oe_ram(S_oe_ram),
      .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
      .S_data_ram_size(S_data_ram_size), .start_port(start_port),
      .done_port(done_port), .busy(busy), .run_done(run_done),
      .timed_out(timed_out), .overflow(overflow), .cycle_count(cycle_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) tick <= tick + 1;

   // Record every write beat and start pulse seen on the ports.
   always @(negedge clock) begin
      if (S_we_ram) begin
         wa_q.push_back(S_addr_ram);
         wd_q.push_back(S_Wdata_ram);
         ws_q.push_back(S_data_ram_size);
      end
      if (start_port) start_cnt <= start_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check(tag, 128'({byte_ready, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                       start_port, busy, run_done, timed_out, overflow, cycle_count}), 128'(0));
   endtask

   // delay: cycles after the start_port cycle at which done_port rises (-1 = never).
   task automatic session(input string nm, input logic [9:0] base, input int n, input bit seq,
                          input bit ld_last, input int gap, input int delay, input bit rst_in_run);
      logic [7:0]  bytes[$];
      logic [9:0]  ea[$];
      logic [63:0] ed[$];
      logic [6:0]  es[$];
      logic [63:0] w;
      int kept, len, idx, t_go, viol, exp_j, exp_cnt, jr, wbase, sbase, nw;
      bit fin, prev_we, seen, exp_to, rdy, did_rst;

      for (int i = 0; i < n; i++) bytes.push_back(seq ? 8'(i + 1) : 8'($urandom_range(255)));
      kept = (n < MEM) ? n : MEM;
      for (int i = 0; i < kept; i += 8) begin
         len = (kept - i < 8) ? kept - i : 8;
         w = '0;
         for (int k = 0; k < len; k++) w = w | (64'(bytes[i + k]) << (8 * k));
         ea.push_back(10'(int'(base) + i));
         ed.push_back(w);
         es.push_back(7'(8 * len));
      end
      if (delay >= 0 && delay < TO) begin
         exp_cnt = delay + 1; exp_to = 1'b0; exp_j = delay + 1;
      end else begin
         exp_cnt = TO; exp_to = 1'b1; exp_j = TO;
      end

      @(negedge clock);
      wbase = wa_q.size();
      sbase = start_cnt;
      go = 1'b1; base_addr = base; t_go = tick;
      @(negedge clock);
      go = 1'b0; base_addr = '0;

      idx = 0; fin = 1'b0; prev_we = 1'b0; viol = 0;
      for (int c = 0; c < 1000 && !fin; c++) begin
         if (c > 0) @(negedge clock);
         rdy = byte_ready;
         if (!rdy && !S_we_ram && !prev_we) viol++;
         prev_we = S_we_ram;
         byte_valid = 1'b0; load_done = 1'b0;
         if (idx < n && $urandom_range(99) >= gap) begin
            byte_valid = 1'b1; byte_data = bytes[idx];
            if (rdy) begin
               idx++;
               if (idx == n && ld_last) begin load_done = 1'b1; fin = 1'b1; end
            end
         end else if (idx == n && rdy) begin
            load_done = 1'b1; fin = 1'b1;
         end
      end
      check({nm, " stream_end"}, 128'(fin), 128'(1));
      check({nm, " no_stall"}, 128'(viol), 128'(0));

      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         byte_valid = 1'b0; load_done = 1'b0;
         if (start_port) begin seen = 1'b1; break; end
      end
      check({nm, " start_seen"}, 128'(seen), 128'(1));
      if (n == 0) check({nm, " start_latency"}, 128'(tick - t_go), 128'(2));

      if (delay == 0) done_port = 1'b1;
      seen = 1'b0; jr = 0; did_rst = 1'b0;
      for (int j = 1; j <= 200; j++) begin
         @(negedge clock);
         if (rst_in_run && j == 10) begin
            reset = 1'b1;
            #1;
            check_zero({nm, " reset_in_run"});
            @(negedge clock);
            reset = 1'b0;
            did_rst = 1'b1;
            break;
         end
         if (run_done) begin seen = 1'b1; jr = j; break; end
         if (j == delay) done_port = 1'b1;
      end

      if (!did_rst) begin
         nw = wa_q.size() - wbase;
         check({nm, " run_done"}, 128'(seen), 128'(1));
         check({nm, " report_cycle"}, 128'(jr), 128'(exp_j));
         check({nm, " cycle_count"}, 128'(cycle_count), 128'(exp_cnt));
         check({nm, " timed_out"}, 128'(timed_out), 128'(exp_to));
         check({nm, " overflow"}, 128'(overflow), 128'(n > MEM));
         check({nm, " busy_report"}, 128'(busy), 128'(1));
         check({nm, " start_pulses"}, 128'(start_cnt - sbase), 128'(1));
         check({nm, " write_count"}, 128'(nw), 128'(ea.size()));
         for (int i = 0; i < ea.size() && i < nw; i++) begin
            check($sformatf("%s w%0d_addr", nm, i), 128'(wa_q[wbase + i]), 128'(ea[i]));
            check($sformatf("%s w%0d_data", nm, i), 128'(wd_q[wbase + i]), 128'(ed[i]));
            check($sformatf("%s w%0d_size", nm, i), 128'(ws_q[wbase + i]), 128'(es[i]));
         end
         done_port = 1'b0;
         @(negedge clock);
         check({nm, " idle_after"}, 128'({busy, run_done}), 128'(0));
         check({nm, " count_held"}, 128'(cycle_count), 128'(exp_cnt));
      end
      done_port = 1'b0;
      $display("[TB] session %s: n=%0d base=%0h delay=%0d reset=%0d", nm, n, base, delay, rst_in_run);
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; base_addr = '0; byte_valid = 1'b0; byte_data = '0;
      load_done = 1'b0; done_port = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("reset_state");
      check("oe_low", 128'(S_oe_ram), 128'(0));
      reset = 1'b0;

      session("tp1",   10'h040, 10, 1'b1, 1'b0, 0, 5, 1'b0);
      done_port = 1'b1;
      session("empty", 10'h123, 0, 1'b0, 1'b0, 0, 0, 1'b0);
      session("ld8",   10'h200, 8, 1'b0, 1'b1, 0, 3, 1'b0);
      session("ovf",   10'h3FC, 20, 1'b0, 1'b0, 0, 2, 1'b0);
      session("tmo",   10'h010, 3, 1'b0, 1'b0, 0, -1, 1'b0);
      session("d49",   10'h020, 5, 1'b0, 1'b1, 30, 49, 1'b0);
      session("d50",   10'h030, 9, 1'b0, 1'b0, 30, 50, 1'b0);
      session("rst",   10'h040, 10, 1'b1, 1'b0, 0, -1, 1'b1);
      session("tp1b",  10'h040, 10, 1'b1, 1'b0, 0, 5, 1'b0);

      for (int r = 0; r < 16; r++) begin
         session($sformatf("rnd%0d", r), 10'($urandom_range(1023)), int'($urandom_range(22)),
                 1'b0, 1'($urandom_range(1)), int'($urandom_range(50)),
                 ($urandom_range(3) == 0) ? -1 : int'($urandom_range(60)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
